// File: rtl/switch_conditioner.sv
// Panel switch front end: synchronises and debounces three raw switches, exposing a
// debounced start/stop level plus increase/decrease strobes with press-and-hold auto-repeat.
module switch_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_PERIOD   = 10000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_start_stop,
    input  logic raw_increase,
    input  logic raw_decrease,
    output logic swt_start_stop,
    output logic swt_increase,
    output logic swt_decrease
);

    localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] DLY_TERM = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PER_TERM = TMR_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } rpt_state_t;

    // Channel 0 is start/stop, 1 is increase, 2 is decrease.
    logic [2:0] raw_s;
    logic [2:0] deb_s;
    logic [1:0] strobe_s;
    logic       both_s;

    assign raw_s  = {raw_decrease, raw_increase, raw_start_stop};
    assign both_s = deb_s[1] & deb_s[2];

    genvar ch;
    for (ch = 0; ch < 3; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_r;
        logic [CNT_W-1:0]       cnt_r;
        logic                   deb_r;

        // Synchroniser chain for the raw asynchronous input.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_r <= {SYNC_STAGES{1'b0}};
            end else begin
                sync_r <= {sync_r[SYNC_STAGES-2:0], raw_s[ch]};
            end
        end

        // Debounce: the level only moves after DEBOUNCE_CYCLES consecutive disagreements.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_r <= CNT_ZERO;
                deb_r <= 1'b0;
            end else if (sync_r[SYNC_STAGES-1] == deb_r) begin
                cnt_r <= CNT_ZERO;
            end else if (cnt_r == CNT_TERM) begin
                cnt_r <= CNT_ZERO;
                deb_r <= sync_r[SYNC_STAGES-1];
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end

        assign deb_s[ch] = deb_r;
    end

    genvar rc;
    for (rc = 0; rc < 2; rc++) begin : g_rpt
        rpt_state_t       state_r;
        logic [TMR_W-1:0] timer_r;
        logic             strobe_r;

        // Repeat FSM: release and neutral (both pressed) take priority over the timer.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_r  <= IDLE;
                timer_r  <= TMR_ZERO;
                strobe_r <= 1'b0;
            end else begin
                strobe_r <= 1'b0;
                case (state_r)
                    IDLE: begin
                        if (deb_s[rc+1] && both_s) begin
                            state_r <= LOCK;
                        end else if (deb_s[rc+1]) begin
                            strobe_r <= 1'b1;
                            timer_r  <= TMR_ZERO;
                            state_r  <= DELAY;
                        end
                    end
                    DELAY: begin
                        if (!deb_s[rc+1]) begin
                            state_r <= IDLE;
                        end else if (both_s) begin
                            state_r <= LOCK;
                        end else if (timer_r == DLY_TERM) begin
                            strobe_r <= 1'b1;
                            timer_r  <= TMR_ZERO;
                            state_r  <= REPEAT;
                        end else begin
                            timer_r <= timer_r + TMR_ONE;
                        end
                    end
                    REPEAT: begin
                        if (!deb_s[rc+1]) begin
                            state_r <= IDLE;
                        end else if (both_s) begin
                            state_r <= LOCK;
                        end else if (timer_r == PER_TERM) begin
                            strobe_r <= 1'b1;
                            timer_r  <= TMR_ZERO;
                        end else begin
                            timer_r <= timer_r + TMR_ONE;
                        end
                    end
                    LOCK: begin
                        // Held switch must be released before it can strobe again.
                        if (!deb_s[rc+1]) begin
                            state_r <= IDLE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        timer_r <= TMR_ZERO;
                    end
                endcase
            end
        end

        assign strobe_s[rc] = strobe_r;
    end

    assign swt_start_stop = deb_s[0];
    assign swt_increase   = strobe_s[0];
    assign swt_decrease   = strobe_s[1];

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner: a press-age model predicts every output each
// cycle, and hand-computed edge numbers pin the strobe positions of each scenario.
module tb_switch_conditioner;

    localparam int S   = 2;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic raw_start_stop = 1'b1;
    logic raw_increase   = 1'b1;
    logic raw_decrease   = 1'b1;
    logic swt_start_stop;
    logic swt_increase;
    logic swt_decrease;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_cnt = 0;
    int inc_q[$];
    int dec_q[$];
    int base;

    switch_conditioner #(
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst),
        .raw_start_stop(raw_start_stop), .raw_increase(raw_increase), .raw_decrease(raw_decrease),
        .swt_start_stop(swt_start_stop), .swt_increase(swt_increase), .swt_decrease(swt_decrease)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Behavioural model: sampled history, run-length debounce, press age -> strobe.
    logic [2:0]   raw_vec;
    logic [S-1:0] m_hist [3];
    logic         m_deb  [3];
    int           m_run  [3];
    int           m_age  [2];
    logic         m_lock [2];
    logic         m_exp  [2];

    assign raw_vec = {raw_decrease, raw_increase, raw_start_stop};

    function automatic logic strobe_at_age(input int a);
        return (a == 1) || (a > RD && ((a - 1 - RD) % RP) == 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 3; c++) begin
                m_hist[c] <= '0;
                m_deb[c]  <= 1'b0;
                m_run[c]  <= 0;
            end
            for (int k = 0; k < 2; k++) begin
                m_age[k]  <= 0;
                m_lock[k] <= 1'b0;
                m_exp[k]  <= 1'b0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                m_hist[c] <= {m_hist[c][S-2:0], raw_vec[c]};
                if (m_hist[c][S-1] == m_deb[c]) begin
                    m_run[c] <= 0;
                end else if (m_run[c] + 1 >= DEB) begin
                    m_deb[c] <= m_hist[c][S-1];
                    m_run[c] <= 0;
                end else begin
                    m_run[c] <= m_run[c] + 1;
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (!m_deb[k+1]) begin
                    m_age[k]  <= 0;
                    m_lock[k] <= 1'b0;
                    m_exp[k]  <= 1'b0;
                end else if (m_lock[k] || (m_deb[1] && m_deb[2])) begin
                    m_lock[k] <= 1'b1;
                    m_exp[k]  <= 1'b0;
                end else begin
                    m_age[k] <= m_age[k] + 1;
                    m_exp[k] <= strobe_at_age(m_age[k] + 1);
                end
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Per-cycle comparison against the model, plus strobe logging by edge number.
    always @(negedge clk) begin
        check("start_stop", swt_start_stop, m_deb[0]);
        check("increase", swt_increase, m_exp[0]);
        check("decrease", swt_decrease, m_exp[1]);
        if (swt_increase === 1'b1) inc_q.push_back(edge_cnt);
        if (swt_decrease === 1'b1) dec_q.push_back(edge_cnt);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic check_q(input string name, input int q[$], input int b, input int exp[$]);
        check_int({name, "_count"}, q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            check_int({name, "_edge"}, (i < q.size()) ? q[i] - b : -1, exp[i]);
        end
    endtask

    task automatic all_zero(input string name);
        check({name, "_ss"}, swt_start_stop, 1'b0);
        check({name, "_inc"}, swt_increase, 1'b0);
        check({name, "_dec"}, swt_decrease, 1'b0);
    endtask

    initial begin
        int ar[$];
        // Reset with all raw inputs high
        #1 rst = 1'b1;
        #1 all_zero("reset_now");
        tick(3);
        all_zero("reset_held");
        raw_start_stop = 1'b0; raw_increase = 1'b0; raw_decrease = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(8);

        // Bounce rejection
        inc_q.delete(); dec_q.delete();
        raw_increase = 1'b1; tick(1);
        raw_increase = 1'b0; tick(1);
        raw_increase = 1'b1; tick(1);
        raw_increase = 1'b0; tick(1);
        raw_increase = 1'b1; base = edge_cnt;
        tick(9);
        raw_increase = 1'b0;
        tick(14);
        check_q("bounce_inc", inc_q, base, '{7});
        check_int("bounce_dec_count", dec_q.size(), 0);

        // Auto-repeat, released 40 cycles after debounce
        inc_q.delete(); dec_q.delete();
        raw_increase = 1'b1; base = edge_cnt;
        tick(46);
        raw_increase = 1'b0;
        tick(14);
        ar.delete();
        ar.push_back(7);
        for (int i = 0; i < 12; i++) ar.push_back(17 + 3 * i);
        check_q("repeat_inc", inc_q, base, ar);

        // Neutral press, partial release, then a fresh press
        inc_q.delete(); dec_q.delete();
        raw_increase = 1'b1; raw_decrease = 1'b1;
        tick(15);
        raw_decrease = 1'b0;
        tick(15);
        raw_increase = 1'b0;
        tick(12);
        check_int("neutral_inc_count", inc_q.size(), 0);
        check_int("neutral_dec_count", dec_q.size(), 0);
        raw_increase = 1'b1; base = edge_cnt;
        tick(9);
        raw_increase = 1'b0;
        tick(14);
        check_q("repress_inc", inc_q, base, '{7});
        check_int("repress_dec_count", dec_q.size(), 0);

        // Start/stop: short pulse rejected, then held level
        raw_start_stop = 1'b1; tick(3);
        raw_start_stop = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check("ss_pulse", swt_start_stop, 1'b0);
        end
        raw_start_stop = 1'b1; base = edge_cnt;
        tick(5); check("ss_rise_e5", swt_start_stop, 1'b0);
        tick(1); check("ss_rise_e6", swt_start_stop, 1'b1);
        tick(4);
        raw_start_stop = 1'b0;
        tick(5); check("ss_fall_e5", swt_start_stop, 1'b1);
        tick(1); check("ss_fall_e6", swt_start_stop, 1'b0);
        tick(6);

        // Reset during REPEAT with decrease and start/stop held
        inc_q.delete(); dec_q.delete();
        raw_decrease = 1'b1; raw_start_stop = 1'b1; base = edge_cnt;
        tick(21);
        check_q("pre_reset_dec", dec_q, base, '{7, 17, 20});
        check("pre_reset_ss", swt_start_stop, 1'b1);
        rst = 1'b1;
        #1 all_zero("midrst_now");
        tick(3);
        all_zero("midrst_held");
        inc_q.delete(); dec_q.delete();
        rst = 1'b0; base = edge_cnt;
        tick(20);
        check_q("post_reset_dec", dec_q, base, '{7, 17, 20});
        check_int("post_reset_inc_count", inc_q.size(), 0);
        raw_decrease = 1'b0; raw_start_stop = 1'b0;
        tick(14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
